fft_seq_ctrl: RTL and testbench
===============================

Name: fft_seq_ctrl

Overview:
- Next-generation ALU control for the RISC-V FFT core.
- Decodes aluop/funct3/funct7 into alufunc exactly as the single-cycle decoder does. It also sequences the multi-cycle FFT custom ops (load, calc, export) over a parametrised point count.
- Sits between ID/EX and the FFT datapath.
- Drives the sample-buffer and butterfly-unit control, and stalls the pipeline while a transform runs.

Parameters:
- N_POINTS, 8, transform size; power of two, 4..1024; LOG2N = $clog2(N_POINTS), AW = LOG2N.
- BF_LAT, 2, butterfly-unit pipeline depth in cycles, 0..8; drained before completion.
- ALUFUNC_W, `aluOP, alufunc width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  instruction in EX is valid; ignored while stall=1.
- aluop  in  2  main-decoder class (`aluR/`aluStore/`aluLoad/`aluBranch).
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- alufunc  out  ALUFUNC_W  ALU function select (combinational).
- stall  out  1  holds the core pipeline.
- load_we  out  1  sample-buffer write strobe.
- load_addr  out  AW  sample-buffer write address (bit-reversed).
- bf_valid  out  1  butterfly issue strobe.
- bf_addr_a  out  AW  butterfly upper operand index.
- bf_addr_b  out  AW  butterfly lower operand index.
- tw_addr  out  AW-1  twiddle ROM index.
- bf_inverse  out  1  conjugate-twiddle select.
- exp_re  out  1  sample-buffer read strobe for export.
- exp_addr  out  AW  export read address (natural order).
- done  out  1  one-cycle pulse when a transform completes.
- err  out  1  one-cycle pulse on an illegal or out-of-sequence op.

Behaviour:
- Reset (rst_n low, async): state IDLE; load_cnt, exp_cnt, stage, bf_idx and drain_cnt = 0; every registered output = 0.
- Reset mid-CALC aborts the transform, with no done pulse.
- alufunc is combinational and never depends on state.
  - R-type, funct3 0: funct7 00/20/01/10/02/03 -> Plus/Sub/Mul/FFTLoad/FFTCAL/FFTExport.
  - R-type, funct3 4/6/7/1/2/3 -> Xor/Or/And/SLL/SLT/SLTU; funct3 5 -> SRA if funct7=20, else SRL.
  - Store -> Plus; Load -> Plus if funct3=2, else LUI.
  - Branch funct3 0/1/4/5 -> BEQ/BNE/BLT/BGE.
  - Any other combination -> alufunc=0, plus an err pulse next cycle if op_valid.
- States: IDLE (load_cnt<N), READY (load_cnt==N), CALC, DRAIN, CALC_DONE.
- FFTLoad accepted in IDLE:
  - load_we=1 and load_addr=bitrev(load_cnt), combinational in the accept cycle.
  - load_cnt increments; reaching N moves to READY.
  - FFTLoad in any other state -> err, no write.
- FFTCAL accepted in READY:
  - stall asserts combinationally in the accept cycle and stays high through the last DRAIN cycle.
  - State becomes CALC next cycle.
  - FFTCAL in any other state -> err, no stall.
- CALC issues one butterfly per cycle, bf_valid registered.
  - Per butterfly, s = stage, j = bf_idx, half = 1<<s: k = j & (half-1), a = ((j>>s)<<(s+1)) + k, b = a + half, tw = k << (LOG2N-1-s).
  - j runs 0..N/2-1, then s increments; after s = LOG2N-1 with j = N/2-1, move to DRAIN.
  - Total issue cycles = LOG2N*N/2.
- DRAIN holds for BF_LAT cycles (0 -> skip), then stall drops, the done pulse fires, state becomes CALC_DONE and exp_cnt = 0.
- FFTExport accepted in CALC_DONE:
  - exp_re=1 and exp_addr=exp_cnt, combinational; exp_cnt increments.
  - After the Nth export: IDLE, load_cnt = 0.
  - FFTExport elsewhere -> err.
- Non-FFT ops are decoded normally in every state, except that op_valid is ignored while stall=1.
- Outputs not being driven by an active phase hold 0.

Optional Feature:
- Macro FFT_IFFT_EN.
- Defined:
  - R-type, funct3 0, funct7 04 decodes to `aluFFTICAL and behaves as FFTCAL.
  - bf_inverse = 1 for every cycle of that run (CALC and DRAIN), 0 otherwise.
- Undefined:
  - funct7 04 is illegal: alufunc = 0, err pulse.
  - bf_inverse is tied to 0.

Test Plan:
- Reset, then 8 FFTLoads (N=8) -> load_addr 0,4,2,6,1,5,3,7; state READY; no err.
- FFTCAL accepted at cycle 0 (N=8, BF_LAT=2) -> bf_valid cycles 1..12; stall high cycles 0..14; done pulse at cycle 15.
- CALC stage-1 sequence -> (a,b,tw) = (0,2,0), (1,3,2), (4,6,0), (5,7,2).
- FFTCAL with load_cnt=5, and FFTExport in IDLE -> err pulse each; no stall, no strobes.
- 8 FFTExports after done -> exp_addr 0..7; state IDLE; a 9th FFTExport -> err.
- rst_n low at CALC cycle 6 -> all outputs 0 immediately; no done pulse; a subsequent FFTCAL -> err.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: ALU function decoder plus FFT load/calc/export sequencer; stalls EX for the transform.
// Optional inverse-transform op (funct7 04, conjugate twiddles) enabled by defining FFT_IFFT_EN.
`ifndef aluOP
`define aluOP 5
`endif
`ifndef aluR
`define aluR 2'd0
`endif
`ifndef aluStore
`define aluStore 2'd1
`endif
`ifndef aluLoad
`define aluLoad 2'd2
`endif
`ifndef aluBranch
`define aluBranch 2'd3
`endif
`ifndef aluPlus
`define aluPlus 1
`define aluSub 2
`define aluMul 3
`define aluFFTLoad 4
`define aluFFTCAL 5
`define aluFFTExport 6
`define aluXor 7
`define aluOr 8
`define aluAnd 9
`define aluSLL 10
`define aluSLT 11
`define aluSLTU 12
`define aluSRA 13
`define aluSRL 14
`define aluLUI 15
`define aluBEQ 16
`define aluBNE 17
`define aluBLT 18
`define aluBGE 19
`define aluFFTICAL 20
`endif

module fft_seq_ctrl #(
  parameter int N_POINTS  = 8,
  parameter int BF_LAT    = 2,
  parameter int ALUFUNC_W = `aluOP,
  localparam int LOG2N    = $clog2(N_POINTS),
  localparam int AW       = LOG2N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  input  logic [1:0]           aluop,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  output logic [ALUFUNC_W-1:0] alufunc,
  output logic                 stall,
  output logic                 load_we,
  output logic [AW-1:0]        load_addr,
  output logic                 bf_valid,
  output logic [AW-1:0]        bf_addr_a,
  output logic [AW-1:0]        bf_addr_b,
  output logic [AW-2:0]        tw_addr,
  output logic                 bf_inverse,
  output logic                 exp_re,
  output logic [AW-1:0]        exp_addr,
  output logic                 done,
  output logic                 err
);

  localparam int HALF_N = N_POINTS / 2;

  localparam logic [ALUFUNC_W-1:0] F_PLUS   = ALUFUNC_W'(`aluPlus);
  localparam logic [ALUFUNC_W-1:0] F_SUB    = ALUFUNC_W'(`aluSub);
  localparam logic [ALUFUNC_W-1:0] F_MUL    = ALUFUNC_W'(`aluMul);
  localparam logic [ALUFUNC_W-1:0] F_FLOAD  = ALUFUNC_W'(`aluFFTLoad);
  localparam logic [ALUFUNC_W-1:0] F_FCAL   = ALUFUNC_W'(`aluFFTCAL);
  localparam logic [ALUFUNC_W-1:0] F_FEXP   = ALUFUNC_W'(`aluFFTExport);
  localparam logic [ALUFUNC_W-1:0] F_XOR    = ALUFUNC_W'(`aluXor);
  localparam logic [ALUFUNC_W-1:0] F_OR     = ALUFUNC_W'(`aluOr);
  localparam logic [ALUFUNC_W-1:0] F_AND    = ALUFUNC_W'(`aluAnd);
  localparam logic [ALUFUNC_W-1:0] F_SLL    = ALUFUNC_W'(`aluSLL);
  localparam logic [ALUFUNC_W-1:0] F_SLT    = ALUFUNC_W'(`aluSLT);
  localparam logic [ALUFUNC_W-1:0] F_SLTU   = ALUFUNC_W'(`aluSLTU);
  localparam logic [ALUFUNC_W-1:0] F_SRA    = ALUFUNC_W'(`aluSRA);
  localparam logic [ALUFUNC_W-1:0] F_SRL    = ALUFUNC_W'(`aluSRL);
  localparam logic [ALUFUNC_W-1:0] F_LUI    = ALUFUNC_W'(`aluLUI);
  localparam logic [ALUFUNC_W-1:0] F_BEQ    = ALUFUNC_W'(`aluBEQ);
  localparam logic [ALUFUNC_W-1:0] F_BNE    = ALUFUNC_W'(`aluBNE);
  localparam logic [ALUFUNC_W-1:0] F_BLT    = ALUFUNC_W'(`aluBLT);
  localparam logic [ALUFUNC_W-1:0] F_BGE    = ALUFUNC_W'(`aluBGE);
`ifdef FFT_IFFT_EN
  localparam logic [ALUFUNC_W-1:0] F_FICAL  = ALUFUNC_W'(`aluFFTICAL);
`endif

  typedef enum logic [2:0] {S_IDLE, S_READY, S_CALC, S_DRAIN, S_CALC_DONE} state_t;

  state_t          state_q;
  logic [AW:0]     load_cnt_q;
  logic [AW-1:0]   exp_cnt_q;
  logic [3:0]      stage_q;
  logic [AW-2:0]   bf_idx_q;
  logic [3:0]      drain_cnt_q;
  logic            bf_valid_q, done_q, err_q;
  logic [AW-1:0]   bf_a_q, bf_b_q;
  logic [AW-2:0]   tw_q;
`ifdef FFT_IFFT_EN
  logic            inv_q;
`endif

  always_comb begin
    alufunc = '0;
    case (aluop)
      `aluR: begin
        case (funct3)
          3'd0: begin
            case (funct7)
              7'h00:   alufunc = F_PLUS;
              7'h20:   alufunc = F_SUB;
              7'h01:   alufunc = F_MUL;
              7'h10:   alufunc = F_FLOAD;
              7'h02:   alufunc = F_FCAL;
              7'h03:   alufunc = F_FEXP;
`ifdef FFT_IFFT_EN
              7'h04:   alufunc = F_FICAL;
`endif
              default: alufunc = '0;
            endcase
          end
          3'd1:    alufunc = F_SLL;
          3'd2:    alufunc = F_SLT;
          3'd3:    alufunc = F_SLTU;
          3'd4:    alufunc = F_XOR;
          3'd5:    alufunc = (funct7 == 7'h20) ? F_SRA : F_SRL;
          3'd6:    alufunc = F_OR;
          default: alufunc = F_AND;
        endcase
      end
      `aluStore: alufunc = F_PLUS;
      `aluLoad:  alufunc = (funct3 == 3'd2) ? F_PLUS : F_LUI;
      default: begin
        case (funct3)
          3'd0:    alufunc = F_BEQ;
          3'd1:    alufunc = F_BNE;
          3'd4:    alufunc = F_BLT;
          3'd5:    alufunc = F_BGE;
          default: alufunc = '0;
        endcase
      end
    endcase
  end

  logic is_load, is_cal, is_exp, is_ical;
  logic busy, op_ok, acc_load, acc_cal, acc_exp, bad_op;

  assign is_load = (alufunc == F_FLOAD);
  assign is_exp  = (alufunc == F_FEXP);
`ifdef FFT_IFFT_EN
  assign is_ical = (alufunc == F_FICAL);
`else
  assign is_ical = 1'b0;
`endif
  assign is_cal  = (alufunc == F_FCAL) || is_ical;

  // op_valid is ignored while the transform holds the pipeline
  assign busy     = (state_q == S_CALC) || (state_q == S_DRAIN);
  assign op_ok    = op_valid && !busy;
  assign acc_load = op_ok && is_load && (state_q == S_IDLE);
  assign acc_cal  = op_ok && is_cal  && (state_q == S_READY);
  assign acc_exp  = op_ok && is_exp  && (state_q == S_CALC_DONE);
  assign bad_op   = op_ok && ((alufunc == '0) ||
                              (is_load && (state_q != S_IDLE)) ||
                              (is_cal  && (state_q != S_READY)) ||
                              (is_exp  && (state_q != S_CALC_DONE)));

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  assign stall     = acc_cal || busy;
  assign load_we   = acc_load;
  assign load_addr = acc_load ? bitrev(load_cnt_q[AW-1:0]) : '0;
  assign exp_re    = acc_exp;
  assign exp_addr  = acc_exp ? exp_cnt_q : '0;
  assign bf_valid  = bf_valid_q;
  assign bf_addr_a = bf_a_q;
  assign bf_addr_b = bf_b_q;
  assign tw_addr   = tw_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef FFT_IFFT_EN
  assign bf_inverse = inv_q;
`else
  assign bf_inverse = 1'b0;
`endif

  // Index/address of the butterfly to issue on the next cycle
  logic          last_bf;
  logic [3:0]    stage_d;
  logic [AW-2:0] bf_idx_d;
  logic [AW-1:0] bf_a_d, bf_b_d;
  logic [AW-2:0] tw_d;

  always_comb begin
    int s, j, half, k, a;
    last_bf  = (stage_q == 4'(LOG2N-1)) && (bf_idx_q == (AW-1)'(HALF_N-1));
    stage_d  = stage_q;
    bf_idx_d = bf_idx_q + 1'b1;
    if (acc_cal) begin
      stage_d  = '0;
      bf_idx_d = '0;
    end else if (bf_idx_q == (AW-1)'(HALF_N-1)) begin
      stage_d  = stage_q + 4'd1;
      bf_idx_d = '0;
    end
    s    = int'(stage_d);
    j    = int'(bf_idx_d);
    half = 1 << s;
    k    = j & (half - 1);
    a    = ((j >> s) << (s + 1)) + k;
    bf_a_d = AW'(a);
    bf_b_d = AW'(a + half);
    tw_d   = (AW-1)'(k << (LOG2N - 1 - s));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      exp_cnt_q   <= '0;
      stage_q     <= '0;
      bf_idx_q    <= '0;
      drain_cnt_q <= '0;
      bf_valid_q  <= 1'b0;
      bf_a_q      <= '0;
      bf_b_q      <= '0;
      tw_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef FFT_IFFT_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      err_q  <= bad_op;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc_load) begin
            load_cnt_q <= load_cnt_q + 1'b1;
            if (load_cnt_q == (AW+1)'(N_POINTS-1)) state_q <= S_READY;
          end
        end
        S_READY: begin
          if (acc_cal) begin
            state_q    <= S_CALC;
            stage_q    <= stage_d;
            bf_idx_q   <= bf_idx_d;
            bf_valid_q <= 1'b1;
            bf_a_q     <= bf_a_d;
            bf_b_q     <= bf_b_d;
            tw_q       <= tw_d;
`ifdef FFT_IFFT_EN
            inv_q      <= is_ical;
`endif
          end
        end
        S_CALC: begin
          if (last_bf) begin
            bf_valid_q <= 1'b0;
            bf_a_q     <= '0;
            bf_b_q     <= '0;
            tw_q       <= '0;
            stage_q    <= '0;
            bf_idx_q   <= '0;
            if (BF_LAT == 0) begin
              state_q   <= S_CALC_DONE;
              done_q    <= 1'b1;
              exp_cnt_q <= '0;
`ifdef FFT_IFFT_EN
              inv_q     <= 1'b0;
`endif
            end else begin
              state_q     <= S_DRAIN;
              drain_cnt_q <= '0;
            end
          end else begin
            stage_q  <= stage_d;
            bf_idx_q <= bf_idx_d;
            bf_a_q   <= bf_a_d;
            bf_b_q   <= bf_b_d;
            tw_q     <= tw_d;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == 4'(BF_LAT-1)) begin
            state_q     <= S_CALC_DONE;
            done_q      <= 1'b1;
            exp_cnt_q   <= '0;
            drain_cnt_q <= '0;
`ifdef FFT_IFFT_EN
            inv_q       <= 1'b0;
`endif
          end else begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end
        S_CALC_DONE: begin
          if (acc_exp) begin
            exp_cnt_q <= exp_cnt_q + 1'b1;
            if (exp_cnt_q == AW'(N_POINTS-1)) begin
              state_q    <= S_IDLE;
              load_cnt_q <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl (N_POINTS=8, BF_LAT=2): load/calc/export sequencing, decoder, errors, reset abort.
module tb_fft_seq_ctrl;
  localparam logic [1:0] A_R = 2'd0, A_ST = 2'd1, A_LD = 2'd2, A_BR = 2'd3;
  localparam int PLUS=1, SUB=2, MUL=3, FLOAD=4, FCAL=5, FEXP=6, XOR_=7, OR_=8, AND_=9,
                 SLL=10, SLT=11, SLTU=12, SRA=13, SRL=14, LUI=15, BEQ=16, BNE=17, BLT=18,
                 BGE=19, FICAL=20;

  logic       clk = 1'b0, rst_n = 1'b1, op_valid = 1'b0;
  logic [1:0] aluop = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [4:0] alufunc;
  logic       stall, load_we, bf_valid, bf_inverse, exp_re, done, err;
  logic [2:0] load_addr, bf_addr_a, bf_addr_b, exp_addr;
  logic [1:0] tw_addr;

  int n_tests = 0, n_fail = 0;
  int ldq[$], bfq[$], exq[$];

  int ld_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int bf_tab[12][3] = '{'{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
                        '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                        '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};
  // {aluop, funct3, funct7, op_valid, expected alufunc, expected err}
  int dec_tab[25][6];

  always #5 clk = ~clk;

  fft_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .aluop(aluop), .funct3(funct3),
    .funct7(funct7), .alufunc(alufunc), .stall(stall), .load_we(load_we),
    .load_addr(load_addr), .bf_valid(bf_valid), .bf_addr_a(bf_addr_a),
    .bf_addr_b(bf_addr_b), .tw_addr(tw_addr), .bf_inverse(bf_inverse), .exp_re(exp_re),
    .exp_addr(exp_addr), .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    op_valid = v; aluop = op; funct3 = f3; funct7 = f7;
  endtask

  function automatic int pack_bf(input int a, input int b, input int t);
    return (a << 5) | (b << 2) | t;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_outs"}, {stall, load_we, load_addr, bf_valid, bf_addr_a, bf_addr_b, tw_addr,
                              bf_inverse, exp_re, exp_addr, done, err}, 0);
  endtask

  always @(negedge clk) begin
    if (load_we) begin
      check_eq("ld_pending", ldq.size() != 0, 1);
      if (ldq.size() != 0) check_eq("ld_addr", load_addr, ldq.pop_front());
    end
    if (bf_valid) begin
      check_eq("bf_pending", bfq.size() != 0, 1);
      if (bfq.size() != 0) check_eq("bf_abt", {bf_addr_a, bf_addr_b, tw_addr}, bfq.pop_front());
    end
    if (exp_re) begin
      check_eq("exp_pending", exq.size() != 0, 1);
      if (exq.size() != 0) check_eq("exp_addr", exp_addr, exq.pop_front());
    end
  end

  initial begin
    dec_tab = '{
      '{0,0,'h00,1,PLUS,0}, '{0,0,'h20,1,SUB,0}, '{0,0,'h01,1,MUL,0}, '{0,4,'h00,1,XOR_,0},
      '{0,6,'h00,1,OR_,0},  '{0,7,'h00,1,AND_,0}, '{0,1,'h00,1,SLL,0}, '{0,2,'h00,1,SLT,0},
      '{0,3,'h00,1,SLTU,0}, '{0,5,'h20,1,SRA,0},  '{0,5,'h00,1,SRL,0}, '{1,3,'h00,1,PLUS,0},
      '{2,2,'h00,1,PLUS,0}, '{2,0,'h00,1,LUI,0},  '{3,0,'h00,1,BEQ,0}, '{3,1,'h00,1,BNE,0},
      '{3,4,'h00,1,BLT,0},  '{3,5,'h00,1,BGE,0},  '{3,2,'h00,1,0,1},   '{0,0,'h7f,1,0,1},
      '{0,0,'h10,0,FLOAD,0}, '{0,0,'h02,0,FCAL,0}, '{0,0,'h03,0,FEXP,0}, '{3,7,'h00,0,0,0},
`ifdef FFT_IFFT_EN
      '{0,0,'h04,1,FICAL,1}
`else
      '{0,0,'h04,1,0,1}
`endif
    };

    #2 rst_n = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, A_R, 3'd0, 7'h10);
      ldq.push_back(ld_tab[i]);
      @(negedge clk);
      check_eq("ld_we", load_we, 1);
      check_eq("ld_stall", stall, 0);
      check_eq("ld_err", err, 0);
    end
    step();
    drive(1'b1, A_R, 3'd0, 7'h10);
    @(negedge clk);
    check_eq("ld_ready_we", load_we, 0);
    check_eq("ld_last_err", err, 0);
    step();
    drive(1'b0, A_R, 3'd0, 7'h00);
    @(negedge clk);
    check_eq("ld_ready_err", err, 1);

    step();
    drive(1'b1, A_R, 3'd0, 7'h02);
    for (int i = 0; i < 12; i++) bfq.push_back(pack_bf(bf_tab[i][0], bf_tab[i][1], bf_tab[i][2]));
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      if (c == 1) drive(1'b1, A_R, 3'd0, 7'h10);
      if (c == 14) drive(1'b0, A_R, 3'd0, 7'h00);
      @(negedge clk);
      check_eq($sformatf("cal_stall_c%0d", c), stall, (c <= 14));
      check_eq($sformatf("cal_bfv_c%0d", c), bf_valid, (c >= 1 && c <= 12));
      check_eq($sformatf("cal_done_c%0d", c), done, (c == 15));
      check_eq($sformatf("cal_err_c%0d", c), err, 0);
      check_eq($sformatf("cal_inv_c%0d", c), bf_inverse, 0);
    end
    check_eq("bfq_drained", bfq.size(), 0);

    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, A_R, 3'd0, 7'h03);
      exq.push_back(i);
      @(negedge clk);
      check_eq("exp_re", exp_re, 1);
      check_eq("exp_err", err, 0);
    end
    step();
    drive(1'b1, A_R, 3'd0, 7'h03);
    @(negedge clk);
    check_eq("exp9_re", exp_re, 0);
    step();
    drive(1'b0, A_R, 3'd0, 7'h00);
    @(negedge clk);
    check_eq("exp9_err", err, 1);

    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b1, A_R, 3'd0, 7'h10);
      ldq.push_back(ld_tab[i]);
    end
    step();
    drive(1'b1, A_R, 3'd0, 7'h02);
    @(negedge clk);
    check_eq("cal5_stall", stall, 0);
    step();
    drive(1'b0, A_R, 3'd0, 7'h00);
    @(negedge clk);
    check_eq("cal5_err", err, 1);
    check_eq("cal5_bfv", bf_valid, 0);
    check_eq("cal5_stall2", stall, 0);

    for (int i = 0; i < 25; i++) begin
      step();
      drive(dec_tab[i][3] != 0, 2'(dec_tab[i][0]), 3'(dec_tab[i][1]), 7'(dec_tab[i][2]));
      @(negedge clk);
      check_eq($sformatf("dec%0d_func", i), alufunc, dec_tab[i][4]);
      check_eq($sformatf("dec%0d_we", i), load_we | exp_re | stall, 0);
      step();
      drive(1'b0, A_R, 3'd0, 7'h00);
      @(negedge clk);
      check_eq($sformatf("dec%0d_err", i), err, dec_tab[i][5]);
    end

    for (int i = 5; i < 8; i++) begin
      step();
      drive(1'b1, A_R, 3'd0, 7'h10);
      ldq.push_back(ld_tab[i]);
    end
    step();
    drive(1'b1, A_R, 3'd0, 7'h02);
    for (int i = 0; i < 5; i++) bfq.push_back(pack_bf(bf_tab[i][0], bf_tab[i][1], bf_tab[i][2]));
    @(negedge clk);
    check_eq("rcal_stall", stall, 1);
    for (int c = 1; c <= 6; c++) begin
      step();
      drive(1'b0, A_R, 3'd0, 7'h00);
      if (c == 6) begin
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid_calc");
      end else begin
        @(negedge clk);
        check_eq($sformatf("rcal_bfv_c%0d", c), bf_valid, 1);
      end
    end
    for (int c = 0; c < 16; c++) begin
      step();
      if (c == 2) rst_n = 1'b1;
      @(negedge clk);
      check_eq($sformatf("rst_nodone_c%0d", c), done | bf_valid | stall, 0);
    end
    step();
    drive(1'b1, A_R, 3'd0, 7'h02);
    @(negedge clk);
    check_eq("post_rst_cal_stall", stall, 0);
    step();
    drive(1'b0, A_R, 3'd0, 7'h00);
    @(negedge clk);
    check_eq("post_rst_cal_err", err, 1);

    check_eq("ldq_empty", ldq.size(), 0);
    check_eq("bfq_empty", bfq.size(), 0);
    check_eq("exq_empty", exq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
